// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment front-end controller.
package seg_pkg;

  typedef enum logic [1:0] {StIdle, StConv, StUpd} state_e;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [3:0]  ERR_DIGIT  = 4'hE;
  localparam int unsigned MAX_DEC    = 99_999_999;

  // Digit i lights if any digit at or above it is nonzero; digit 0 always lights.
  function automatic logic [NUM_DIGITS-1:0] digit_mask(input logic [4*NUM_DIGITS-1:0] bcd,
                                                      input logic blank);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen = seen | (bcd[4*i +: 4] != 4'd0);
      m[i] = seen | ~blank;
    end
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one input bit per cycle while run is high, MSB first.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  input  logic                    run,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0]        sh_q, sh_d;
  logic [4*NUM_DIGITS-1:0] acc_q, acc_d, adj;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    last;

  assign last = (cnt_q == CntW'(BIN_W - 1));

  // Per-nibble add-3 correction, no carry between nibbles.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
  end

  always_comb begin
    sh_d  = sh_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      sh_d  = bin;
      acc_d = '0;
      cnt_d = '0;
    end else if (run) begin
      sh_d  = sh_q << 1;
      acc_d = {adj[4*NUM_DIGITS-2:0], sh_q[BIN_W-1]};
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = run & last;
  assign bcd  = acc_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Binary-to-display front end: handshake, BCD conversion, blanking/overflow and scan enable.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W       = 27,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BIN_W-1:0]        value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_zeros,
  input  logic                    display_en,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   anodes_mask,
  output logic                    ce,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned PreW = $clog2(REFRESH_DIV);

  state_e                  state_q, state_d;
  logic                    start, run, upd, conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    blank_q, ovf_pend_q;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, an_q, an_d;
  logic                    ovf_q, ovf_d;
  logic [PreW-1:0]         pre_q, pre_d;
  logic                    pre_wrap;

  bin2bcd_seq #(
    .BIN_W(BIN_W)
  ) u_bin2bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (value),
    .run  (run),
    .done (conv_done),
    .bcd  (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (value_valid) state_d = StConv;
      StConv:  if (conv_done)   state_d = StUpd;
      StUpd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    value_ready = (state_q == StIdle);
    busy        = ~value_ready;
    start       = value_valid & value_ready;
    run         = (state_q == StConv);
    upd         = (state_q == StUpd);
  end

  // Digits, mask and overflow commit together; the anode register follows mask_d so
  // the visible mask changes on the same edge as the digits.
  always_comb begin
    digits_d = digits_q;
    mask_d   = mask_q;
    ovf_d    = ovf_q;
    if (upd) begin
      if (ovf_pend_q) begin
        digits_d = {NUM_DIGITS{ERR_DIGIT}};
        mask_d   = '1;
        ovf_d    = 1'b1;
      end else begin
        digits_d = bcd;
        mask_d   = digit_mask(bcd, blank_q);
        ovf_d    = 1'b0;
      end
    end
    an_d = display_en ? mask_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      mask_q     <= NUM_DIGITS'(1);
      an_q       <= NUM_DIGITS'(1);
      ovf_q      <= 1'b0;
    end else begin
      if (start) begin
        blank_q    <= blank_zeros;
        ovf_pend_q <= (64'(value) > 64'(MAX_DEC));
      end
      digits_q <= digits_d;
      mask_q   <= mask_d;
      an_q     <= an_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pre_wrap = (pre_q == PreW'(REFRESH_DIV - 1));
  assign pre_d    = pre_wrap ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  assign ce          = pre_wrap;
  assign digits      = digits_q;
  assign anodes_mask = an_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: fixed vectors, random vectors, corner sequences.
module tb_seg_display_ctrl;

  localparam int unsigned BIN_W = 27;
  localparam int unsigned RDIV  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BIN_W-1:0]  value;
  logic              value_valid;
  logic              value_ready;
  logic              blank_zeros;
  logic              display_en;
  logic [31:0]       digits;
  logic [7:0]        anodes_mask;
  logic              ce;
  logic              busy;
  logic              overflow;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .BIN_W      (BIN_W),
    .REFRESH_DIV(RDIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .blank_zeros(blank_zeros),
    .display_en (display_en),
    .digits     (digits),
    .anodes_mask(anodes_mask),
    .ce         (ce),
    .busy       (busy),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [BIN_W-1:0] value;
    logic             blank;
    logic [31:0]      digits;
    logic [7:0]       mask;
    logic             ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, mask from the highest nonzero digit.
  task automatic model(input logic [BIN_W-1:0] v, input logic b, output logic [31:0] d,
                       output logic [7:0] m, output logic o);
    longint unsigned x;
    int              hi;
    x  = longint'(v);
    hi = -1;
    if (x > 64'd99_999_999) begin
      d = 32'hEEEE_EEEE;
      m = 8'hFF;
      o = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        d[4*i +: 4] = 4'(x % 10);
        if (x % 10 != 0) hi = i;
        x = x / 10;
      end
      for (int i = 0; i < 8; i++) m[i] = !b || (i <= hi) || (i == 0);
      o = 1'b0;
    end
  endtask

  task automatic run_conv(input string tag, input logic [BIN_W-1:0] v, input logic b,
                          input logic [31:0] ed, input logic [7:0] em, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!value_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready_wait"}, 32'(value_ready), 32'd1);
    value       = v;
    blank_zeros = b;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    value       = BIN_W'($urandom);
    repeat (BIN_W) @(posedge clk);
    #1;
    chk({tag, ".busy_last"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, ".digits"}, digits, ed);
    chk({tag, ".mask"}, 32'(anodes_mask), 32'(em));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    chk({tag, ".ready"}, 32'(value_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ed;
    logic [7:0]  em;
    logic        eo;
    logic [BIN_W-1:0] rv;
    logic        rb;
    int          n, pulses, last_ce;

    vecs[0] = '{27'd12_345_678,  1'b0, 32'h1234_5678, 8'hFF, 1'b0};
    vecs[1] = '{27'd42,          1'b1, 32'h0000_0042, 8'h03, 1'b0};
    vecs[2] = '{27'd0,           1'b1, 32'h0000_0000, 8'h01, 1'b0};
    vecs[3] = '{27'd100_000_000, 1'b0, 32'hEEEE_EEEE, 8'hFF, 1'b1};
    vecs[4] = '{27'd7,           1'b1, 32'h0000_0007, 8'h01, 1'b0};
    vecs[5] = '{27'd0,           1'b0, 32'h0000_0000, 8'hFF, 1'b0};
    vecs[6] = '{27'd99_999_999,  1'b1, 32'h9999_9999, 8'hFF, 1'b0};
    vecs[7] = '{27'd10_000_000,  1'b1, 32'h1000_0000, 8'hFF, 1'b0};
    vecs[8] = '{27'd1_000,       1'b1, 32'h0000_1000, 8'h0F, 1'b0};

    rst_n       = 1'b0;
    value       = '0;
    value_valid = 1'b0;
    blank_zeros = 1'b0;
    display_en  = 1'b1;
    #12;
    chk("rst.digits", digits, 32'h0);
    chk("rst.mask", 32'(anodes_mask), 32'h01);
    chk("rst.ce", 32'(ce), 32'd0);
    chk("rst.ready", 32'(value_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].blank, vecs[i].digits,
               vecs[i].mask, vecs[i].ovf);

    for (int i = 0; i < 20; i++) begin
      rv = (i % 4 == 3) ? BIN_W'($urandom) : BIN_W'($urandom_range(0, 99_999_999));
      if (i % 5 == 1) rv = BIN_W'($urandom_range(0, 9999));
      rb = 1'($urandom);
      model(rv, rb, ed, em, eo);
      run_conv($sformatf("rnd%0d", i), rv, rb, ed, em, eo);
    end

    // Scan enable keeps its cadence while a conversion runs.
    @(negedge clk);
    value       = 27'd99;
    blank_zeros = 1'b1;
    value_valid = 1'b1;
    pulses      = 0;
    last_ce     = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      value_valid = 1'b0;
      if (ce) begin
        if (last_ce >= 0) chk($sformatf("ce.spacing%0d", i), 32'(i - last_ce), 32'd4);
        last_ce = i;
        pulses++;
      end
    end
    chk("ce.pulses", 32'(pulses), 32'd10);
    chk("ce.conv_digits", digits, 32'h99);

    // Valid during CONV is ignored.
    @(negedge clk);
    value       = 27'd99;
    blank_zeros = 1'b1;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 3) begin
        value       = 27'd5;
        value_valid = 1'b1;
      end else begin
        value_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    value_valid = 1'b0;
    chk("ign.busy_cycles", 32'(n), 32'(BIN_W + 1));
    chk("ign.digits", digits, 32'h99);
    chk("ign.mask", 32'(anodes_mask), 32'h03);
    repeat (40) @(negedge clk);
    chk("ign.digits_later", digits, 32'h99);
    chk("ign.idle_later", 32'(busy), 32'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    value       = 27'd12_345_678;
    blank_zeros = 1'b0;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.digits", digits, 32'h0);
    chk("mid.mask", 32'(anodes_mask), 32'h01);
    chk("mid.ce", 32'(ce), 32'd0);
    chk("mid.ready", 32'(value_ready), 32'd1);
    chk("mid.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid.no_partial", digits, 32'h0);

    // Display enable gating restores the held mask.
    run_conv("den", 27'd4321, 1'b1, 32'h4321, 8'h0F, 1'b0);
    @(negedge clk);
    display_en = 1'b0;
    #1;
    chk("den.before_edge", 32'(anodes_mask), 32'h0F);
    @(negedge clk);
    chk("den.off", 32'(anodes_mask), 32'h00);
    chk("den.digits_kept", digits, 32'h4321);
    display_en = 1'b1;
    @(negedge clk);
    chk("den.on", 32'(anodes_mask), 32'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
